// File: rtl/tsc_mc_control_pkg.sv
// rtl/tsc_mc_control_pkg.sv - TSC opcodes, FSM states and control-select constants
//
// Purpose: shared encodings for the TSC multicycle control unit: ISA
// opcode/func values, FSM state encoding, instruction classes, PC source,
// ALU compare result, ALU operation and datapath select constants.
// Ports: none (package).

package tsc_mc_control_pkg;

  // ISA opcodes, IR[15:12]
  localparam logic [3:0] OP_BNE   = 4'd0;
  localparam logic [3:0] OP_BEQ   = 4'd1;
  localparam logic [3:0] OP_BGZ   = 4'd2;
  localparam logic [3:0] OP_BLZ   = 4'd3;
  localparam logic [3:0] OP_ADI   = 4'd4;
  localparam logic [3:0] OP_ORI   = 4'd5;
  localparam logic [3:0] OP_LHI   = 4'd6;
  localparam logic [3:0] OP_LWD   = 4'd7;
  localparam logic [3:0] OP_SWD   = 4'd8;
  localparam logic [3:0] OP_JMP   = 4'd9;
  localparam logic [3:0] OP_JAL   = 4'd10;
  localparam logic [3:0] OP_RTYPE = 4'd15;

  // R-type func codes, IR[5:0]
  localparam logic [5:0] FN_ADD = 6'd0;
  localparam logic [5:0] FN_SUB = 6'd1;
  localparam logic [5:0] FN_AND = 6'd2;
  localparam logic [5:0] FN_ORR = 6'd3;
  localparam logic [5:0] FN_NOT = 6'd4;
  localparam logic [5:0] FN_TCP = 6'd5;
  localparam logic [5:0] FN_SHL = 6'd6;
  localparam logic [5:0] FN_SHR = 6'd7;
  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CLS_NOP    = 4'd0,
    CLS_RTYPE  = 4'd1,
    CLS_IALU   = 4'd2,
    CLS_LWD    = 4'd3,
    CLS_SWD    = 4'd4,
    CLS_BRANCH = 4'd5,
    CLS_JMP    = 4'd6,
    CLS_JAL    = 4'd7,
    CLS_JPR    = 4'd8,
    CLS_JRL    = 4'd9,
    CLS_WWD    = 4'd10,
    CLS_HLT    = 4'd11
  } inst_cls_e;

  // PC source select
  localparam logic [1:0] PC_SEQ     = 2'd0;
  localparam logic [1:0] PC_ALUOUT  = 2'd1;
  localparam logic [1:0] PC_JTARGET = 2'd2;
  localparam logic [1:0] PC_REG     = 2'd3;

  // ALU_Cmp: A versus B
  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_GT = 2'b01;
  localparam logic [1:0] CMP_LT = 2'b10;

  // ALU operations
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_ORR = 4'd3;
  localparam logic [3:0] ALU_NOT = 4'd4;
  localparam logic [3:0] ALU_TCP = 4'd5;
  localparam logic [3:0] ALU_SHL = 4'd6;
  localparam logic [3:0] ALU_SHR = 4'd7;
  localparam logic [3:0] ALU_LHI = 4'd8;
  localparam logic [3:0] ALU_CMP = 4'd9;

  // Datapath selects
  localparam logic [1:0] REGDST_RD = 2'd0;
  localparam logic [1:0] REGDST_RT = 2'd1;
  localparam logic [1:0] REGDST_R2 = 2'd2;

  localparam logic [1:0] WSRC_ALU = 2'd0;
  localparam logic [1:0] WSRC_MEM = 2'd1;
  localparam logic [1:0] WSRC_PC  = 2'd2;

  localparam logic [1:0] ALUSRCA_RF_RS  = 2'd0;
  localparam logic [1:0] ALUSRCA_SEQ_PC = 2'd1;

  localparam logic [1:0] ALUSRCB_RF_RT    = 2'd0;
  localparam logic [1:0] ALUSRCB_I_OFFSET = 2'd1;
  localparam logic [1:0] ALUSRCB_ZERO     = 2'd2;

  // Branch condition from the EX-state compare of rs against rt or zero.
  function automatic logic branch_taken(input logic [3:0] opcode, input logic [1:0] cmp);
    logic taken;
    taken = 1'b0;
    case (opcode)
      OP_BEQ:  taken = (cmp == CMP_EQ);
      OP_BNE:  taken = (cmp != CMP_EQ);
      OP_BGZ:  taken = (cmp == CMP_GT);
      OP_BLZ:  taken = (cmp == CMP_LT);
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/tsc_ctrl_decode.sv
// rtl/tsc_ctrl_decode.sv - opcode/func to instruction class and EX-state ALU controls
//
// Purpose: combinational decode of the latched instruction fields.
// Ports:
//   opcode_i     in  4  IR[15:12]
//   func_i       in  6  IR[5:0]
//   cls_o        out    instruction class (undefined encodings -> CLS_NOP)
//   ex_aluop_o   out 4  ALU operation used in EX
//   ex_alusrcb_o out 2  ALU operand B select used in EX

module tsc_ctrl_decode
  import tsc_mc_control_pkg::*;
(
  input  logic [3:0] opcode_i,
  input  logic [5:0] func_i,
  output inst_cls_e  cls_o,
  output logic [3:0] ex_aluop_o,
  output logic [1:0] ex_alusrcb_o
);

  always_comb begin
    cls_o        = CLS_NOP;
    ex_aluop_o   = ALU_ADD;
    ex_alusrcb_o = ALUSRCB_I_OFFSET;
    case (opcode_i)
      OP_BNE, OP_BEQ: begin
        cls_o        = CLS_BRANCH;
        ex_aluop_o   = ALU_CMP;
        ex_alusrcb_o = ALUSRCB_RF_RT;
      end
      OP_BGZ, OP_BLZ: begin
        // sign tests compare rs against a constant zero operand
        cls_o        = CLS_BRANCH;
        ex_aluop_o   = ALU_CMP;
        ex_alusrcb_o = ALUSRCB_ZERO;
      end
      OP_ADI: cls_o = CLS_IALU;
      OP_ORI: begin
        cls_o      = CLS_IALU;
        ex_aluop_o = ALU_ORR;
      end
      OP_LHI: begin
        cls_o      = CLS_IALU;
        ex_aluop_o = ALU_LHI;
      end
      OP_LWD: cls_o = CLS_LWD;
      OP_SWD: cls_o = CLS_SWD;
      OP_JMP: cls_o = CLS_JMP;
      OP_JAL: cls_o = CLS_JAL;
      OP_RTYPE: begin
        ex_alusrcb_o = ALUSRCB_RF_RT;
        case (func_i)
          FN_ADD: begin cls_o = CLS_RTYPE; ex_aluop_o = ALU_ADD; end
          FN_SUB: begin cls_o = CLS_RTYPE; ex_aluop_o = ALU_SUB; end
          FN_AND: begin cls_o = CLS_RTYPE; ex_aluop_o = ALU_AND; end
          FN_ORR: begin cls_o = CLS_RTYPE; ex_aluop_o = ALU_ORR; end
          FN_NOT: begin cls_o = CLS_RTYPE; ex_aluop_o = ALU_NOT; end
          FN_TCP: begin cls_o = CLS_RTYPE; ex_aluop_o = ALU_TCP; end
          FN_SHL: begin cls_o = CLS_RTYPE; ex_aluop_o = ALU_SHL; end
          FN_SHR: begin cls_o = CLS_RTYPE; ex_aluop_o = ALU_SHR; end
          FN_JPR: cls_o = CLS_JPR;
          FN_JRL: cls_o = CLS_JRL;
          FN_WWD: cls_o = CLS_WWD;
          FN_HLT: cls_o = CLS_HLT;
          default: cls_o = CLS_NOP;
        endcase
      end
      default: cls_o = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/tsc_mc_control.sv
// rtl/tsc_mc_control.sv - TSC multicycle control FSM with memory handshake and retire counter
//
// Purpose: sequences IF/ID/EX/MEM/WB/HALT and drives the datapath controls.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   opcode, func         latched instruction fields
//   ALU_Cmp              compare result of the current ALU inputs
//   inputReady           memory completion pulse
//   readM, writeM        memory requests, held until inputReady
//   IRWrite, RegWrite    IR load / register-file write enables
//   RegDst, RegWriteSrc  write-address and write-data selects
//   ALUOp, ALUSrcA/B     ALU operation and operand selects
//   PCWrite, PCSrc       PC update strobe and source
//   output_active        WWD port strobe
//   is_halted            HLT reached
//   num_inst             retired instruction count

module tsc_mc_control
  import tsc_mc_control_pkg::*;
#(
  parameter int WORD_SIZE  = 16,
  parameter int NUM_INST_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            opcode,
  input  logic [5:0]            func,
  input  logic [1:0]            ALU_Cmp,
  input  logic                  inputReady,
  output logic                  readM,
  output logic                  writeM,
  output logic                  IRWrite,
  output logic                  RegWrite,
  output logic [1:0]            RegDst,
  output logic [1:0]            RegWriteSrc,
  output logic [3:0]            ALUOp,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic                  PCWrite,
  output logic [1:0]            PCSrc,
  output logic                  output_active,
  output logic                  is_halted,
  output logic [NUM_INST_W-1:0] num_inst
);

  // The opcode/func field positions are fixed by the 16-bit TSC encoding.
  if (WORD_SIZE != 16) begin : g_word_size_check
    $error("tsc_mc_control: WORD_SIZE must be 16");
  end

  state_e                  state_q, state_d;
  logic [NUM_INST_W-1:0]   num_inst_q, num_inst_d;
  inst_cls_e               cls;
  logic [3:0]              ex_aluop;
  logic [1:0]              ex_alusrcb;

  tsc_ctrl_decode u_decode (
    .opcode_i     (opcode),
    .func_i       (func),
    .cls_o        (cls),
    .ex_aluop_o   (ex_aluop),
    .ex_alusrcb_o (ex_alusrcb)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IF;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF: if (inputReady) state_d = S_ID;
      S_ID: begin
        case (cls)
          CLS_JMP, CLS_JPR, CLS_WWD, CLS_NOP: state_d = S_IF;
          CLS_JAL, CLS_JRL:                   state_d = S_WB;
          CLS_HLT:                            state_d = S_HALT;
          default:                            state_d = S_EX;
        endcase
      end
      S_EX: begin
        case (cls)
          CLS_BRANCH:       state_d = S_IF;
          CLS_LWD, CLS_SWD: state_d = S_MEM;
          default:          state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (cls != CLS_LWD && cls != CLS_SWD) begin
          state_d = S_IF;
        end else if (inputReady) begin
          state_d = (cls == CLS_LWD) ? S_WB : S_IF;
        end
      end
      S_WB:   state_d = S_IF;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  // Output logic; every PCWrite pulse marks a retired instruction.
  always_comb begin
    readM         = 1'b0;
    writeM        = 1'b0;
    IRWrite       = 1'b0;
    RegWrite      = 1'b0;
    RegDst        = '0;
    RegWriteSrc   = '0;
    ALUOp         = '0;
    ALUSrcA       = '0;
    ALUSrcB       = '0;
    PCWrite       = 1'b0;
    PCSrc         = '0;
    output_active = 1'b0;
    is_halted     = 1'b0;
    if (!reset) begin
      case (state_q)
        S_IF: begin
          readM   = 1'b1;
          IRWrite = inputReady;
        end
        S_ID: begin
          // Precompute PC+1+imm so EX/branches can use ALUOut as the target.
          ALUSrcA = ALUSRCA_SEQ_PC;
          ALUSrcB = ALUSRCB_I_OFFSET;
          ALUOp   = ALU_ADD;
          case (cls)
            CLS_JMP: begin PCWrite = 1'b1; PCSrc = PC_JTARGET; end
            CLS_JPR: begin PCWrite = 1'b1; PCSrc = PC_REG; end
            CLS_WWD: begin PCWrite = 1'b1; PCSrc = PC_SEQ; output_active = 1'b1; end
            CLS_NOP: begin PCWrite = 1'b1; PCSrc = PC_SEQ; end
            default: ;
          endcase
        end
        S_EX: begin
          ALUSrcA = ALUSRCA_RF_RS;
          ALUSrcB = ex_alusrcb;
          ALUOp   = ex_aluop;
          if (cls == CLS_BRANCH) begin
            PCWrite = 1'b1;
            PCSrc   = branch_taken(opcode, ALU_Cmp) ? PC_ALUOUT : PC_SEQ;
          end
        end
        S_MEM: begin
          readM  = (cls == CLS_LWD);
          writeM = (cls == CLS_SWD);
          if (cls == CLS_SWD && inputReady) begin
            PCWrite = 1'b1;
            PCSrc   = PC_SEQ;
          end
        end
        S_WB: begin
          RegWrite = 1'b1;
          PCWrite  = 1'b1;
          case (cls)
            CLS_RTYPE: begin RegDst = REGDST_RD; RegWriteSrc = WSRC_ALU; PCSrc = PC_SEQ; end
            CLS_LWD:   begin RegDst = REGDST_RT; RegWriteSrc = WSRC_MEM; PCSrc = PC_SEQ; end
            CLS_JAL:   begin RegDst = REGDST_R2; RegWriteSrc = WSRC_PC;  PCSrc = PC_JTARGET; end
            CLS_JRL:   begin RegDst = REGDST_R2; RegWriteSrc = WSRC_PC;  PCSrc = PC_REG; end
            default:   begin RegDst = REGDST_RT; RegWriteSrc = WSRC_ALU; PCSrc = PC_SEQ; end
          endcase
        end
        S_HALT: is_halted = 1'b1;
        default: ;
      endcase
    end
  end

  // Retired-instruction counter, wraps naturally at 2^NUM_INST_W.
  always_comb begin
    num_inst_d = num_inst_q;
    if (PCWrite) num_inst_d = num_inst_q + NUM_INST_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      num_inst_q <= '0;
    end else begin
      num_inst_q <= num_inst_d;
    end
  end

  assign num_inst = num_inst_q;

endmodule

// File: tb/tb_tsc_mc_control.sv
// tb/tb_tsc_mc_control.sv - directed self-checking bench for tsc_mc_control

module tb_tsc_mc_control;
  import tsc_mc_control_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  opcode;
  logic [5:0]  func;
  logic [1:0]  alu_cmp;
  logic        input_ready;
  logic        readM, writeM, IRWrite, RegWrite, PCWrite, output_active, is_halted;
  logic [1:0]  RegDst, RegWriteSrc, ALUSrcA, ALUSrcB, PCSrc;
  logic [3:0]  ALUOp;
  logic [15:0] num_inst;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_num  = 0;

  always #5 clk = ~clk;

  tsc_mc_control #(.WORD_SIZE(16), .NUM_INST_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .func          (func),
    .ALU_Cmp       (alu_cmp),
    .inputReady    (input_ready),
    .readM         (readM),
    .writeM        (writeM),
    .IRWrite       (IRWrite),
    .RegWrite      (RegWrite),
    .RegDst        (RegDst),
    .RegWriteSrc   (RegWriteSrc),
    .ALUOp         (ALUOp),
    .ALUSrcA       (ALUSrcA),
    .ALUSrcB       (ALUSrcB),
    .PCWrite       (PCWrite),
    .PCSrc         (PCSrc),
    .output_active (output_active),
    .is_halted     (is_halted),
    .num_inst      (num_inst)
  );

  // {readM, writeM, IRWrite, RegWrite, RegDst, RegWriteSrc, ALUOp, ALUSrcA, ALUSrcB, PCWrite, PCSrc, output_active, is_halted}
  logic [20:0] ov_now;
  assign ov_now = {readM, writeM, IRWrite, RegWrite, RegDst, RegWriteSrc, ALUOp,
                   ALUSrcA, ALUSrcB, PCWrite, PCSrc, output_active, is_halted};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [20:0] ev(input logic rd, input logic wr, input logic irw,
                                     input logic rw, input logic [1:0] rdst,
                                     input logic [1:0] wsrc, input logic [3:0] aop,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic pcw, input logic [1:0] pcs,
                                     input logic oa, input logic hlt);
    return {rd, wr, irw, rw, rdst, wsrc, aop, sa, sb, pcw, pcs, oa, hlt};
  endfunction

  function automatic logic [20:0] e_fetch(input logic irw);
    return ev(1'b1, 1'b0, irw, 1'b0, 2'd0, 2'd0, 4'd0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
  endfunction

  function automatic logic [20:0] e_id(input logic pcw, input logic [1:0] pcs, input logic oa);
    return ev(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, ALU_ADD, ALUSRCA_SEQ_PC, ALUSRCB_I_OFFSET,
              pcw, pcs, oa, 1'b0);
  endfunction

  function automatic logic [20:0] e_ex(input logic [3:0] aop, input logic [1:0] sb,
                                       input logic pcw, input logic [1:0] pcs);
    return ev(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, aop, ALUSRCA_RF_RS, sb, pcw, pcs, 1'b0, 1'b0);
  endfunction

  function automatic logic [20:0] e_mem(input logic rd, input logic wr, input logic pcw);
    return ev(rd, wr, 1'b0, 1'b0, 2'd0, 2'd0, 4'd0, 2'd0, 2'd0, pcw, PC_SEQ, 1'b0, 1'b0);
  endfunction

  function automatic logic [20:0] e_wb(input logic [1:0] rdst, input logic [1:0] wsrc,
                                       input logic [1:0] pcs);
    return ev(1'b0, 1'b0, 1'b0, 1'b1, rdst, wsrc, 4'd0, 2'd0, 2'd0, 1'b1, pcs, 1'b0, 1'b0);
  endfunction

  // Inputs are already applied (posedge+1); check at negedge, then step one cycle.
  task automatic cyc(input string tag, input logic [20:0] exp);
    @(negedge clk);
    check(tag, 32'(ov_now), 32'(exp));
    check({tag, ".num"}, 32'(num_inst), 32'(exp_num));
    @(posedge clk);
    #1;
    if (reset) exp_num = 0;
    else if (exp[4]) exp_num = (exp_num + 1) % 65536;
  endtask

  task automatic run_branch(input string tag, input logic [3:0] op, input logic [1:0] cmp,
                            input logic [1:0] sb, input logic taken);
    opcode  = op;
    alu_cmp = cmp;
    cyc({tag, ".if"}, e_fetch(1'b1));
    cyc({tag, ".id"}, e_id(1'b0, 2'd0, 1'b0));
    cyc({tag, ".ex"}, e_ex(ALU_CMP, sb, 1'b1, taken ? PC_ALUOUT : PC_SEQ));
  endtask

  initial begin
    reset = 1'b1; opcode = 4'd0; func = 6'd0; alu_cmp = CMP_EQ; input_ready = 1'b0;
    @(posedge clk);
    #1;
    cyc("rst", 21'd0);
    reset = 1'b0;

    // ADD: IF, ID, EX, WB
    opcode = OP_RTYPE; func = FN_ADD; input_ready = 1'b1;
    cyc("add.if", e_fetch(1'b1));
    cyc("add.id", e_id(1'b0, 2'd0, 1'b0));
    cyc("add.ex", e_ex(ALU_ADD, ALUSRCB_RF_RT, 1'b0, 2'd0));
    cyc("add.wb", e_wb(REGDST_RD, WSRC_ALU, PC_SEQ));

    // LWD with 3 wait cycles in IF and MEM; inputReady high in ID/EX is ignored
    opcode = OP_LWD; input_ready = 1'b0;
    repeat (3) cyc("lwd.if_wait", e_fetch(1'b0));
    input_ready = 1'b1;
    cyc("lwd.if", e_fetch(1'b1));
    cyc("lwd.id", e_id(1'b0, 2'd0, 1'b0));
    cyc("lwd.ex", e_ex(ALU_ADD, ALUSRCB_I_OFFSET, 1'b0, 2'd0));
    input_ready = 1'b0;
    repeat (3) cyc("lwd.mem_wait", e_mem(1'b1, 1'b0, 1'b0));
    input_ready = 1'b1;
    cyc("lwd.mem", e_mem(1'b1, 1'b0, 1'b0));
    cyc("lwd.wb", e_wb(REGDST_RT, WSRC_MEM, PC_SEQ));

    // Branches
    run_branch("beq_eq", OP_BEQ, CMP_EQ, ALUSRCB_RF_RT, 1'b1);
    run_branch("beq_gt", OP_BEQ, CMP_GT, ALUSRCB_RF_RT, 1'b0);
    run_branch("bgz_gt", OP_BGZ, CMP_GT, ALUSRCB_ZERO,  1'b1);
    run_branch("blz_gt", OP_BLZ, CMP_GT, ALUSRCB_ZERO,  1'b0);
    run_branch("bne_lt", OP_BNE, CMP_LT, ALUSRCB_RF_RT, 1'b1);

    // JAL: 3 cycles, link to r2
    opcode = OP_JAL;
    cyc("jal.if", e_fetch(1'b1));
    cyc("jal.id", e_id(1'b0, 2'd0, 1'b0));
    cyc("jal.wb", e_wb(REGDST_R2, WSRC_PC, PC_JTARGET));

    // JMP, JPR and an undefined opcode all retire from ID
    opcode = OP_JMP;
    cyc("jmp.if", e_fetch(1'b1));
    cyc("jmp.id", e_id(1'b1, PC_JTARGET, 1'b0));
    opcode = OP_RTYPE; func = FN_JPR;
    cyc("jpr.if", e_fetch(1'b1));
    cyc("jpr.id", e_id(1'b1, PC_REG, 1'b0));
    opcode = 4'd12;
    cyc("undef.if", e_fetch(1'b1));
    cyc("undef.id", e_id(1'b1, PC_SEQ, 1'b0));

    // ORI: I-type ALU writes rt
    opcode = OP_ORI;
    cyc("ori.if", e_fetch(1'b1));
    cyc("ori.id", e_id(1'b0, 2'd0, 1'b0));
    cyc("ori.ex", e_ex(ALU_ORR, ALUSRCB_I_OFFSET, 1'b0, 2'd0));
    cyc("ori.wb", e_wb(REGDST_RT, WSRC_ALU, PC_SEQ));

    // SWD completing with zero wait
    opcode = OP_SWD;
    cyc("swd.if", e_fetch(1'b1));
    cyc("swd.id", e_id(1'b0, 2'd0, 1'b0));
    cyc("swd.ex", e_ex(ALU_ADD, ALUSRCB_I_OFFSET, 1'b0, 2'd0));
    cyc("swd.mem", e_mem(1'b0, 1'b1, 1'b1));

    // WWD then HLT
    opcode = OP_RTYPE; func = FN_WWD;
    cyc("wwd.if", e_fetch(1'b1));
    cyc("wwd.id", e_id(1'b1, PC_SEQ, 1'b1));
    func = FN_HLT;
    cyc("hlt.if", e_fetch(1'b1));
    cyc("hlt.id", e_id(1'b0, 2'd0, 1'b0));
    for (int i = 0; i < 20; i++) begin
      input_ready = i[0];
      cyc("hlt.hold", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 4'd0, 2'd0, 2'd0,
                         1'b0, 2'd0, 1'b0, 1'b1));
    end
    reset = 1'b1;
    cyc("hlt.rst", 21'd0);
    reset = 1'b0; input_ready = 1'b1;

    // SWD interrupted by reset while writeM is pending
    opcode = OP_SWD;
    cyc("swd2.if", e_fetch(1'b1));
    cyc("swd2.id", e_id(1'b0, 2'd0, 1'b0));
    cyc("swd2.ex", e_ex(ALU_ADD, ALUSRCB_I_OFFSET, 1'b0, 2'd0));
    input_ready = 1'b0;
    cyc("swd2.mem", e_mem(1'b0, 1'b1, 1'b0));
    reset = 1'b1;
    cyc("rst.mid", 21'd0);
    cyc("rst.hold", 21'd0);
    reset = 1'b0;
    cyc("rel.if", e_fetch(1'b0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tsc_mc_control.md
Name: tsc_mc_control

Overview:
- Multicycle control unit for the TSC 16-bit CPU; drives the control side of the datapath.
- Outputs: IRWrite, RegWrite, RegDst, RegWriteSrc, ALUOp, ALUSrcA, ALUSrcB.
- Consumes the latched instruction fields and ALU_Cmp from the datapath.
- Sequences IF/ID/EX/MEM/WB, owns the PC-update strobe and the memory read/write handshake, and counts retired instructions.

Parameters:
- WORD_SIZE, 16, datapath/instruction width.
- NUM_INST_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  4  IR[15:12] from the datapath latch.
- func  in  6  IR[5:0].
- ALU_Cmp  in  2  comparison result of the current ALU inputs.
- inputReady  in  1  memory completion pulse for the current read or write.
- readM / writeM  out  1 each  memory request, held until inputReady.
- IRWrite  out  1  load IR.
- RegWrite  out  1  register-file write enable.
- RegDst / RegWriteSrc  out  2 each  write-address and write-data select.
- ALUOp  out  4  ALU operation.
- ALUSrcA / ALUSrcB  out  2 each  ALU operand selects.
- PCWrite  out  1  PC update strobe.
- PCSrc  out  2  PC_SEQ, PC_ALUOUT, PC_JTARGET, PC_REG.
- output_active  out  1  WWD port strobe.
- is_halted  out  1  HLT reached.
- num_inst  out  NUM_INST_W  retired instruction count.

Behaviour:
- States: IF, ID, EX, MEM, WB, HALT (encoding in package).
- Outputs are a function of state, opcode/func and inputReady.
- Register-file and ALU select outputs take datapath-package constant names.
- Reset:
  - Reset high at a clk edge: state <- IF, num_inst <- 0, is_halted <- 0.
  - While reset is high, every output except num_inst is forced 0.
  - Reset wins over every state, including mid-handshake and HALT.
- IF:
  - readM=1.
  - Stays in IF while inputReady=0.
  - inputReady=1: IRWrite=1 same cycle, next state ID.
  - The first fetch after reset release asserts readM in the first cycle.
- ID (ALU precomputes PC+1+imm):
  - ALUSrcA=Seq_PC, ALUSrcB=I_OFFSET, ALUOp=ADD; result lands in ALUOut for EX.
  - JMP: PCWrite with PC_JTARGET, retire, next state IF.
  - JPR: PCWrite with PC_REG, retire, next state IF.
  - JAL/JRL: next state WB.
  - WWD: output_active=1, PCWrite with PC_SEQ, retire, next state IF.
  - HLT: next state HALT.
  - Undefined opcode/func: treat as NOP (PC_SEQ, retire).
  - All others: next state EX.
- EX:
  - R-type: ALUSrcA=RF_rs, ALUSrcB=RF_rt, ALUOp from func.
  - ADI/ORI/LHI/LWD/SWD: ALUSrcA=RF_rs, ALUSrcB=I_OFFSET.
  - Branches:
    - ALUOp=CMP. B = RF_rt for BEQ/BNE, zero select for BGZ/BLZ.
    - Taken when: BEQ on CMP_EQ; BNE on not CMP_EQ; BGZ on CMP_GT; BLZ on CMP_LT.
    - PCWrite asserted in EX; PCSrc = PC_ALUOUT if taken, else PC_SEQ.
    - Retire; next state IF.
  - LWD/SWD go to MEM; the rest go to WB.
- MEM:
  - LWD asserts readM; SWD asserts writeM. Held until inputReady.
  - SWD completion: PCWrite PC_SEQ, retire, next state IF.
  - LWD completion: next state WB.
- WB:
  - RegWrite=1. Retire with PCWrite PC_SEQ, except JAL/JRL, which retire with PC_JTARGET and PC_REG respectively.
  - Data/address selects:
    - R-type: ALU data, rd.
    - I-type ALU: ALU data, rt.
    - LWD: MEM data, rt.
    - JAL/JRL: PC data, register 2.
  - Next state IF.
- Retire = exactly one PCWrite pulse plus num_inst+1 in the same cycle; num_inst wraps modulo 2^NUM_INST_W.
- HALT: is_halted=1, no requests, no PCWrite, held until reset.
- readM and writeM are never high together.
- inputReady arriving outside a request is ignored.
- Minimum cycles (zero-wait memory):
  - 2: JMP, JPR, WWD.
  - 3: JAL, JRL, branches.
  - 4: R-type, I-type ALU, SWD.
  - 5: LWD.

Decomposition:
- Extend the shared opcodes package with:
  - state encoding;
  - PCSrc constants;
  - CMP_EQ=2'b00, CMP_GT=2'b01, CMP_LT=2'b10 (A versus B);
  - ALUOp constants, including CMP.
- Reuse the existing RegDst, RegWriteSrc and ALUSrc constants unchanged.
- One sub-module: tsc_ctrl_decode, a combinational map from opcode/func to instruction class and EX-state ALUOp/ALUSrcB.
- The FSM, handshake and counter stay in the top module.

Test Plan:
- ADD (opcode 15, func 0), inputReady on the first IF cycle:
  - IF,ID,EX,WB over 4 cycles; WB has RegWrite=1 with rd destination and PCWrite with PC_SEQ.
  - num_inst 0->1.
- LWD with inputReady delayed 3 cycles in both IF and MEM:
  - readM high 4 cycles each time; IRWrite only on the ready cycle.
  - 11 cycles total; WB selects MEM data to rt.
- BEQ with ALU_Cmp=CMP_EQ, then again with CMP_GT:
  - First: PCWrite with PC_ALUOUT in EX. Second: PCWrite with PC_SEQ in EX.
  - RegWrite=0 throughout both.
- JAL:
  - 3 cycles; WB writes PC data to register 2; PCWrite with PC_JTARGET.
- WWD then HLT:
  - output_active pulses 1 cycle in ID.
  - HLT: is_halted=1, no readM for 20 cycles, num_inst frozen.
- Reset asserted during MEM of SWD with writeM high:
  - Next cycle all outputs 0 while reset is held, num_inst=0.
  - After release, IF with readM=1.
